// File: rtl/hzrd_pkg.sv
// hzrd_pkg: shared stage-entry type and select-width helper for the hazard controller
package hzrd_pkg;
  localparam int MAX_ADDR_W = 16;
  typedef struct packed {
    logic                  wen;
    logic [MAX_ADDR_W-1:0] waddr;
    logic                  is_load;
  } stage_t;
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/hzrd_fwd_sel.sv
// hzrd_fwd_sel: youngest-match forward select and load-use detect for one source operand
module hzrd_fwd_sel import hzrd_pkg::*; #(
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = sel_w(DEPTH)
) (
  input  stage_t                stg [DEPTH],
  input  logic [MAX_ADDR_W-1:0] src,
  output logic [SEL_W-1:0]      sel,
  output logic                  load_use
);
  // scan oldest to youngest so the smallest matching stage wins
  always_comb begin
    sel      = '0;
    load_use = 1'b0;
    for (int k = DEPTH; k >= 1; k--)
      if (stg[k-1].wen && stg[k-1].waddr == src && src != '0) begin
        sel      = SEL_W'(k);
        load_use = stg[k-1].is_load && k < LOAD_STAGE;
      end
  end
endmodule

// File: rtl/hzrd_ctrl.sv
// hzrd_ctrl: pipeline hazard tracker with forwarding selects, load-use stall and stall counter
module hzrd_ctrl import hzrd_pkg::*; #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = sel_w(DEPTH),
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_wen,
  input  logic [ADDR_W-1:0] i_rd_waddr,
  input  logic [ADDR_W-1:0] i_rs1_raddr,
  input  logic [ADDR_W-1:0] i_rs2_raddr,
  input  logic              i_is_load,
  input  logic              i_flush,
  input  logic              i_mem_busy,
  output logic              o_if_id_halt,
  output logic              o_id_ex_halt,
  output logic [SEL_W-1:0]  o_fwd_sel_rs1,
  output logic [SEL_W-1:0]  o_fwd_sel_rs2,
  output logic [CNT_W-1:0]  o_stall_cnt
);
  stage_t stg [DEPTH];
  logic   hz1, hz2, load_use, stall;

  hzrd_fwd_sel #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) u_rs1 (
    .stg(stg), .src(MAX_ADDR_W'(i_rs1_raddr)), .sel(o_fwd_sel_rs1), .load_use(hz1)
  );
  hzrd_fwd_sel #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) u_rs2 (
    .stg(stg), .src(MAX_ADDR_W'(i_rs2_raddr)), .sel(o_fwd_sel_rs2), .load_use(hz2)
  );

  assign load_use     = hz1 | hz2;
  assign stall        = load_use & ~i_flush & ~i_mem_busy;
  assign o_if_id_halt = i_rst_n & (i_mem_busy | stall);
  assign o_id_ex_halt = i_rst_n & (i_mem_busy | stall);

  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    stage_t d;
    if (g == 0) begin : g_head
      assign d = (i_flush | load_use) ? '0 : stage_t'{i_rd_wen, MAX_ADDR_W'(i_rd_waddr), i_is_load};
    end else begin : g_tail
      assign d = stg[g-1];
    end
    // advance this stage unless memory freezes the whole pipeline
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) stg[g] <= '0;
      else if (!i_mem_busy) stg[g] <= d;
  end

  // count load-use bubbles, sticking at all-ones
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_stall_cnt <= '0;
    else if (stall && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
endmodule

// File: tb/tb_hzrd_ctrl.sv
// tb_hzrd_ctrl: directed and random checks of hzrd_ctrl against a behavioural pipeline model
module tb_hzrd_ctrl;
  logic       clk = 1'b1, rst_n = 1'b0;
  logic       rd_wen = 0, is_load = 0, flush = 0, busy = 0;
  logic [4:0] rd_waddr = 0, rs1 = 0, rs2 = 0;
  logic       a_ifh, a_idh, b_ifh, b_idh;
  logic [1:0] a_s1, a_s2;
  logic [2:0] b_s1, b_s2;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;
  int total = 0, fails = 0;

  bit m_wen [2][9];
  int m_wa  [2][9];
  bit m_ld  [2][9];
  int m_cnt [2];
  const int dep [2] = '{2, 4};
  const int ls  [2] = '{2, 3};
  const int cmax[2] = '{65535, 15};

  always #5 clk = ~clk;

  hzrd_ctrl u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_wen(rd_wen), .i_rd_waddr(rd_waddr),
    .i_rs1_raddr(rs1), .i_rs2_raddr(rs2), .i_is_load(is_load), .i_flush(flush),
    .i_mem_busy(busy), .o_if_id_halt(a_ifh), .o_id_ex_halt(a_idh),
    .o_fwd_sel_rs1(a_s1), .o_fwd_sel_rs2(a_s2), .o_stall_cnt(a_cnt)
  );
  hzrd_ctrl #(.DEPTH(4), .LOAD_STAGE(3), .CNT_W(4)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_wen(rd_wen), .i_rd_waddr(rd_waddr),
    .i_rs1_raddr(rs1), .i_rs2_raddr(rs2), .i_is_load(is_load), .i_flush(flush),
    .i_mem_busy(busy), .o_if_id_halt(b_ifh), .o_id_ex_halt(b_idh),
    .o_fwd_sel_rs1(b_s1), .o_fwd_sel_rs2(b_s2), .o_stall_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int msel(int d, int s);
    if (s == 0) return 0;
    for (int k = 1; k <= dep[d]; k++)
      if (m_wen[d][k] && m_wa[d][k] == s) return k;
    return 0;
  endfunction

  function automatic bit mhz(int d);
    int a = msel(d, int'(rs1));
    int b = msel(d, int'(rs2));
    return (a != 0 && m_ld[d][a] && a < ls[d]) || (b != 0 && m_ld[d][b] && b < ls[d]);
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      for (int k = 0; k < 9; k++) begin
        m_wen[d][k] = 0; m_wa[d][k] = 0; m_ld[d][k] = 0;
      end
    end
  endtask

  task automatic mstep();
    for (int d = 0; d < 2; d++) begin
      bit h = mhz(d);
      if (!busy) begin
        for (int k = dep[d]; k >= 2; k--) begin
          m_wen[d][k] = m_wen[d][k-1]; m_wa[d][k] = m_wa[d][k-1]; m_ld[d][k] = m_ld[d][k-1];
        end
        m_wen[d][1] = !(flush || h) && rd_wen;
        m_wa[d][1]  = (flush || h) ? 0 : int'(rd_waddr);
        m_ld[d][1]  = !(flush || h) && is_load;
        if (h && !flush && m_cnt[d] < cmax[d]) m_cnt[d]++;
      end
    end
  endtask

  task automatic chk_model();
    bit h0 = mhz(0), h1 = mhz(1);
    chk("u0_if_id_halt", a_ifh, busy | (h0 & !flush));
    chk("u0_id_ex_halt", a_idh, busy | (h0 & !flush));
    chk("u0_sel_rs1", a_s1, msel(0, int'(rs1)));
    chk("u0_sel_rs2", a_s2, msel(0, int'(rs2)));
    chk("u0_stall_cnt", a_cnt, m_cnt[0]);
    chk("u1_if_id_halt", b_ifh, busy | (h1 & !flush));
    chk("u1_id_ex_halt", b_idh, busy | (h1 & !flush));
    chk("u1_sel_rs1", b_s1, msel(1, int'(rs1)));
    chk("u1_sel_rs2", b_s2, msel(1, int'(rs2)));
    chk("u1_stall_cnt", b_cnt, m_cnt[1]);
  endtask

  task automatic tick();
    @(negedge clk);
    chk_model();
    @(posedge clk);
    mstep();
    #1;
  endtask

  task automatic setin(input bit w, input int wa, input bit ld, input int r1, input int r2);
    rd_wen = w; rd_waddr = 5'(wa); is_load = ld; rs1 = 5'(r1); rs2 = 5'(r2);
    flush = 0; busy = 0;
  endtask

  task automatic chk_zero();
    chk("rst_u0_halts", {a_ifh, a_idh}, 0);
    chk("rst_u0_sels", {a_s1, a_s2}, 0);
    chk("rst_u0_cnt", a_cnt, 0);
    chk("rst_u1_halts", {b_ifh, b_idh}, 0);
    chk("rst_u1_sels", {b_s1, b_s2}, 0);
    chk("rst_u1_cnt", b_cnt, 0);
  endtask

  initial begin
    mreset();
    #2;
    chk_zero();
    rst_n = 1;
    // youngest single producer forwards from EX
    setin(1, 5, 0, 0, 0); tick();
    setin(0, 0, 0, 5, 0); #1;
    chk("fwd_ex_sel", a_s1, 1);
    chk("fwd_ex_halt", a_ifh, 0);
    tick();
    // load-use: one bubble on default, two on the deeper instance
    setin(1, 7, 1, 0, 0); tick();
    setin(0, 0, 0, 0, 7); #1;
    chk("lu_u0_halt1", a_ifh, 1);
    chk("lu_u0_sel1", a_s2, 1);
    chk("lu_u1_halt1", b_ifh, 1);
    tick();
    chk("lu_u0_halt2", a_ifh, 0);
    chk("lu_u0_sel2", a_s2, 2);
    chk("lu_u0_cnt", a_cnt, 1);
    chk("lu_u1_halt2", b_ifh, 1);
    tick();
    chk("lu_u1_halt3", b_ifh, 0);
    chk("lu_u1_sel3", b_s2, 3);
    chk("lu_u1_cnt", b_cnt, 2);
    setin(0, 0, 0, 0, 0); tick();
    // youngest of two producers wins; x0 never matches
    setin(1, 9, 0, 0, 0); tick(); tick();
    setin(0, 0, 0, 9, 0); #1;
    chk("yng_u0_sel", a_s1, 1);
    chk("yng_u1_sel", b_s1, 1);
    setin(1, 0, 0, 0, 0); tick();
    setin(0, 0, 0, 0, 0); #1;
    chk("x0_sel", a_s1, 0);
    tick();
    // busy freezes a pending load-use, then flush masks it
    setin(1, 3, 1, 0, 0); tick();
    setin(0, 0, 0, 3, 0);
    busy = 1;
    repeat (3) begin
      #1;
      chk("busy_halt", a_ifh, 1);
      chk("busy_sel", a_s1, 1);
      chk("busy_cnt", a_cnt, 1);
      tick();
    end
    busy = 0; flush = 1; #1;
    chk("flush_if_halt", a_ifh, 0);
    chk("flush_ex_halt", a_idh, 0);
    tick();
    flush = 0; #1;
    chk("flush_sel", a_s1, 2);
    chk("flush_cnt", a_cnt, 1);
    tick();
    setin(0, 0, 0, 0, 0); tick();
    // 20 bubbles on the 4-bit counter must saturate at 15
    repeat (10) begin
      setin(1, 4, 1, 0, 0); tick();
      setin(0, 0, 0, 4, 0); tick(); tick();
    end
    chk("sat_cnt", b_cnt, 15);
    // asynchronous reset in the middle of a stall
    setin(1, 4, 1, 0, 0); tick();
    setin(0, 0, 0, 4, 0); #1;
    chk("pre_rst_halt", a_ifh, 1);
    rst_n = 0; #1;
    chk_zero();
    mreset();
    rst_n = 1; #1;
    chk("post_rst_halt", a_ifh, 0);
    tick();
    // random traffic on a small register set
    repeat (400) begin
      setin(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      flush = $urandom_range(0, 7) == 0;
      busy  = $urandom_range(0, 7) == 0;
      tick();
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
